// File: rtl/writeback_commit_pkg.sv
// Shared definitions for the writeback/commit stage:
// opcode and load funct codes, width defaults, write decoder.
package writeback_commit_pkg;

  localparam int XLEN_D = 32;
  localparam int EX_W_D = 4;

  localparam logic [4:0] OP_LOAD      = 5'b00000;
  localparam logic [4:0] OP_IMM_ARITH = 5'b00100;
  localparam logic [4:0] OP_AUIPC     = 5'b00101;
  localparam logic [4:0] OP_ARITH     = 5'b01100;
  localparam logic [4:0] OP_LUI       = 5'b01101;
  localparam logic [4:0] OP_JALR      = 5'b11001;
  localparam logic [4:0] OP_JAL       = 5'b11011;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  // Opcodes that produce a register result
  function automatic logic writes_rd(input logic [4:0] op);
    logic w;
    w = 1'b0;
    case (op)
      OP_LOAD, OP_IMM_ARITH, OP_AUIPC, OP_ARITH,
      OP_LUI, OP_JALR, OP_JAL: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/writeback_commit_load_align.sv
// Load-data alignment: sign/zero extension of
// right-aligned byte/half loads.
module load_align
  import writeback_commit_pkg::*;
#(
  parameter int XLEN = XLEN_D
) (
  input  logic [2:0]      funct,
  input  logic [XLEN-1:0] result,
  output logic [XLEN-1:0] data
);

  // Extend according to the load width/signedness
  always_comb begin
    data = result;
    unique case (funct)
      F_LB:  data = {{(XLEN-8){result[7]}}, result[7:0]};
      F_LH:  data = {{(XLEN-16){result[15]}}, result[15:0]};
      F_LW:  data = result;
      F_LBU: data = {{(XLEN-8){1'b0}}, result[7:0]};
      F_LHU: data = {{(XLEN-16){1'b0}}, result[15:0]};
      default: data = result;
    endcase
  end

endmodule

// File: rtl/writeback_commit.sv
// Final pipeline stage: regfile commit, trap flush,
// sticky halt and retired-instruction counting.
module writeback_commit
  import writeback_commit_pkg::*;
#(
  parameter int              XLEN         = XLEN_D,
  parameter int              REG_ADDR_W   = 5,
  parameter int              EX_W         = EX_W_D,
  parameter int              CNT_W        = 64,
  parameter logic [XLEN-1:0] TRAP_VEC     = 'h100,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       PC,
  input  logic [31:0]           instr,
  input  logic [4:0]            opcode,
  input  logic [2:0]            funct,
  input  logic                  nop_instr,
  input  logic [XLEN-1:0]       result,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  exception_valid,
  input  logic [EX_W-1:0]       exception,
  input  logic                  pipeline_valid,
  input  logic                  halt_in,
  output logic                  flush,
  output logic [XLEN-1:0]       flush_addr,
  output logic                  halt_out,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [XLEN-1:0]       wr_data,
  output logic                  wr_enable,
  output logic [XLEN-1:0]       trap_epc,
  output logic [EX_W-1:0]       trap_cause,
  output logic [31:0]           trap_tval,
  output logic [CNT_W-1:0]      retired
);

  typedef enum logic [1:0] {
    RUN,
    TRAP,
    HALTED
  } state_t;

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  state_t          state;
  logic [FC_W-1:0] flush_cnt;
  logic            fire;
  logic            retire;
  logic            commit;
  logic [XLEN-1:0] aligned;
  logic [XLEN-1:0] commit_data;

  load_align #(.XLEN(XLEN)) u_align (
    .funct  (funct),
    .result (result),
    .data   (aligned)
  );

  assign fire        = pipeline_valid && (state == RUN);
  assign retire      = fire && !exception_valid && !nop_instr;
  assign commit      = retire && writes_rd(opcode)
                       && (rd_addr != '0);
  assign commit_data = (opcode == OP_LOAD) ? aligned : result;

  assign wr_enable = commit;
  assign wr_addr   = commit ? rd_addr : '0;
  assign wr_data   = commit ? commit_data : '0;

  // Commit FSM: trap capture, timed flush, sticky halt, retire count
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      flush      <= 1'b0;
      flush_addr <= '0;
      flush_cnt  <= '0;
      halt_out   <= 1'b0;
      trap_epc   <= '0;
      trap_cause <= '0;
      trap_tval  <= '0;
      retired    <= '0;
    end else begin
      if (retire)
        retired <= retired + 1'b1;
      unique case (state)
        RUN: begin
          if (fire && exception_valid) begin
            state      <= TRAP;
            flush      <= 1'b1;
            flush_addr <= TRAP_VEC;
            flush_cnt  <= FC_W'(FLUSH_CYCLES - 1);
            trap_epc   <= PC;
            trap_cause <= exception;
            trap_tval  <= instr;
          end else if (fire && halt_in) begin
            state    <= HALTED;
            halt_out <= 1'b1;
          end
        end
        TRAP: begin
          if (flush_cnt == '0) begin
            state      <= RUN;
            flush      <= 1'b0;
            flush_addr <= '0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_commit.sv
// Randomized + directed bench for writeback_commit
// against a behavioural commit/trap/halt model.
module tb_writeback_commit;
  import writeback_commit_pkg::*;

  localparam int          CW = 4;
  localparam int          FC = 2;
  localparam logic [31:0] TV = 32'h100;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] instr;
  logic [4:0]  opcode;
  logic [2:0]  funct;
  logic        nop_instr;
  logic [31:0] result;
  logic [4:0]  rd_addr;
  logic        exception_valid;
  logic [3:0]  exception;
  logic        pipeline_valid;
  logic        halt_in;
  logic        flush;
  logic [31:0] flush_addr;
  logic        halt_out;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_enable;
  logic [31:0] trap_epc;
  logic [3:0]  trap_cause;
  logic [31:0] trap_tval;
  logic [CW-1:0] retired;

  writeback_commit #(.CNT_W(CW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .PC(PC), .instr(instr),
    .opcode(opcode), .funct(funct), .nop_instr(nop_instr),
    .result(result), .rd_addr(rd_addr),
    .exception_valid(exception_valid), .exception(exception),
    .pipeline_valid(pipeline_valid), .halt_in(halt_in),
    .flush(flush), .flush_addr(flush_addr), .halt_out(halt_out),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .trap_epc(trap_epc), .trap_cause(trap_cause),
    .trap_tval(trap_tval), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  int          m_left;
  bit          m_halt;
  int          m_ret;
  logic [31:0] m_epc;
  logic [3:0]  m_cause;
  logic [31:0] m_tval;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit has_rd(logic [4:0] op);
    logic [4:0] ops [7];
    ops = '{5'b00000, 5'b00100, 5'b00101, 5'b01100,
            5'b01101, 5'b11001, 5'b11011};
    foreach (ops[i]) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_data(logic [4:0] op,
                                           logic [2:0] f,
                                           logic [31:0] r);
    logic [31:0] v;
    v = r;
    if (op == 5'b00000) begin
      if (f == 3'd0) begin
        v = r & 32'hFF;
        if (v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else if (f == 3'd1) begin
        v = r & 32'hFFFF;
        if (v >= 32'd32768) v = v | 32'hFFFF_0000;
      end else if (f == 3'd4) begin
        v = r & 32'hFF;
      end else if (f == 3'd5) begin
        v = r & 32'hFFFF;
      end
    end
    return v;
  endfunction

  // Compare all DUT outputs with the model (called mid-cycle)
  task automatic compare();
    bit fire, we;
    fire = pipeline_valid && m_left == 0 && !m_halt;
    we = fire && !exception_valid && !nop_instr
         && has_rd(opcode) && rd_addr != 0;
    chk("wr_enable", wr_enable, we);
    chk("wr_addr", wr_addr, we ? rd_addr : 5'd0);
    chk("wr_data", wr_data,
        we ? exp_data(opcode, funct, result) : 32'd0);
    chk("flush", flush, m_left > 0);
    chk("flush_addr", flush_addr, m_left > 0 ? TV : 32'd0);
    chk("halt_out", halt_out, m_halt);
    chk("trap_epc", trap_epc, m_epc);
    chk("trap_cause", trap_cause, m_cause);
    chk("trap_tval", trap_tval, m_tval);
    chk("retired", retired, m_ret % 16);
  endtask

  task automatic model_edge();
    if (reset) begin
      m_left = 0; m_halt = 0; m_ret = 0;
      m_epc = 0; m_cause = 0; m_tval = 0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (!m_halt && pipeline_valid) begin
      if (exception_valid) begin
        m_left = FC;
        m_epc = PC; m_cause = exception; m_tval = instr;
      end else begin
        if (!nop_instr) m_ret = (m_ret + 1) % 16;
        if (halt_in) m_halt = 1;
      end
    end
  endtask

  task automatic tick_a();
    @(negedge clk);
    compare();
  endtask

  task automatic tick_b();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    tick_a();
    tick_b();
  endtask

  task automatic idle();
    reset = 0; PC = 0; instr = 0; opcode = 0; funct = 0;
    nop_instr = 0; result = 0; rd_addr = 0;
    exception_valid = 0; exception = 0;
    pipeline_valid = 0; halt_in = 0;
  endtask

  task automatic op(logic [4:0] o, logic [4:0] rd,
                    logic [31:0] r, logic [2:0] f);
    idle();
    pipeline_valid = 1; opcode = o; rd_addr = rd;
    result = r; funct = f;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    idle();
    m_left = 0; m_halt = 0; m_ret = 0;
    m_epc = 0; m_cause = 0; m_tval = 0;
    reset = 1;
    @(posedge clk); #1;
    model_edge();
    do_reset();

    // reset state pinned
    tick_a();
    chk("rst_flush", flush, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halt", halt_out, 0);
    tick_b();

    // 1: arithmetic write
    op(OP_ARITH, 5'd5, 32'h1234, 3'd0);
    tick_a();
    chk("t1_we", wr_enable, 1);
    chk("t1_addr", wr_addr, 5);
    chk("t1_data", wr_data, 32'h1234);
    tick_b();
    idle();
    tick_a();
    chk("t1_ret", retired, 1);
    tick_b();

    // 2: load alignment and x0
    op(OP_LOAD, 5'd6, 32'h80, 3'b000);
    tick_a();
    chk("t2_lb", wr_data, 32'hFFFF_FF80);
    tick_b();
    op(OP_LOAD, 5'd6, 32'h80, 3'b100);
    tick_a();
    chk("t2_lbu", wr_data, 32'h80);
    tick_b();
    op(OP_ARITH, 5'd0, 32'h55, 3'd0);
    tick_a();
    chk("t2_x0", wr_enable, 0);
    tick_b();
    idle();
    tick_a();
    chk("t2_ret", retired, 4);
    tick_b();

    // 3: exception flush
    op(OP_ARITH, 5'd7, 32'h1, 3'd0);
    exception_valid = 1; exception = 4'd2;
    PC = 32'h40; instr = 32'hFFFF_FFFF;
    step();
    for (int i = 0; i < 2; i++) begin
      op(OP_ARITH, 5'd9, 32'h9, 3'd0);
      tick_a();
      chk("t3_flush", flush, 1);
      chk("t3_faddr", flush_addr, 32'h100);
      chk("t3_we", wr_enable, 0);
      tick_b();
    end
    idle();
    tick_a();
    chk("t3_flush_end", flush, 0);
    chk("t3_epc", trap_epc, 32'h40);
    chk("t3_cause", trap_cause, 2);
    chk("t3_tval", trap_tval, 32'hFFFF_FFFF);
    chk("t3_ret", retired, 4);
    tick_b();

    // 4: halt
    op(OP_LUI, 5'd3, 32'hABCD_0000, 3'd0);
    halt_in = 1;
    tick_a();
    chk("t4_we", wr_enable, 1);
    tick_b();
    for (int i = 0; i < 10; i++) begin
      op(OP_ARITH, 5'd8, 32'(i), 3'd0);
      tick_a();
      chk("t4_halted", halt_out, 1);
      chk("t4_nowr", wr_enable, 0);
      tick_b();
    end
    do_reset();
    tick_a();
    chk("t4_rst", halt_out, 0);
    tick_b();

    // 5: exception beats halt; reset during flush
    op(OP_ARITH, 5'd2, 32'h2, 3'd0);
    exception_valid = 1; exception = 4'd5; halt_in = 1;
    step();
    idle();
    reset = 1;
    tick_a();
    chk("t5_flush", flush, 1);
    chk("t5_nohalt", halt_out, 0);
    tick_b();
    op(OP_ARITH, 5'd4, 32'h44, 3'd0);
    tick_a();
    chk("t5_flush0", flush, 0);
    chk("t5_we", wr_enable, 1);
    tick_b();

    // 6: counter wrap with bubbles
    do_reset();
    for (int i = 0; i < 16; i++) begin
      op(OP_IMM_ARITH, 5'(i), 32'(i), 3'd0);
      step();
      op(OP_ARITH, 5'd1, 32'h0, 3'd0);
      nop_instr = 1;
      step();
    end
    idle();
    tick_a();
    chk("t6_wrap", retired, 0);
    tick_b();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [4:0] ops [8];
      ops = '{OP_LOAD, OP_IMM_ARITH, OP_AUIPC, OP_ARITH,
              OP_LUI, OP_JALR, OP_JAL, 5'b01000};
      idle();
      reset = ($urandom_range(0, 99) < 3);
      pipeline_valid = ($urandom_range(0, 9) < 8);
      opcode = ops[$urandom_range(0, 7)];
      funct = 3'($urandom);
      rd_addr = 5'($urandom);
      result = $urandom;
      PC = $urandom;
      instr = $urandom;
      nop_instr = ($urandom_range(0, 9) == 0);
      exception_valid = ($urandom_range(0, 9) == 0);
      exception = 4'($urandom);
      halt_in = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_commit.md
Name: writeback_commit

Overview:
Parametrised successor to the single-cycle writeback stage, and the final pipeline stage of the core.
- Commits results to the register file, with load-data alignment and x0 write suppression.
- Turns exceptions into a timed pipeline flush to a trap vector, and records trap state (epc/cause/tval).
- Makes halt sticky and counts retired instructions.
- Outputs are driven by a three-state commit FSM.

Parameters:
XLEN, 32, data/address width (PC, result, register data)
REG_ADDR_W, 5, register-file address width
EX_W, 4, exception-code width
CNT_W, 64, retired-instruction counter width
TRAP_VEC, 32'h0000_0100, flush target on exception
FLUSH_CYCLES, 2, cycles flush stays high per trap (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
PC  in  XLEN  PC of instruction in stage
instr  in  32  raw instruction word
opcode  in  5  instr[6:2]
funct  in  3  instr[14:12]
nop_instr  in  1  instruction is a bubble/NOP
result  in  XLEN  execute/memory result; load data right-aligned, raw
rd_addr  in  REG_ADDR_W  destination register
exception_valid  in  1  instruction raised an exception
exception  in  EX_W  exception code
pipeline_valid  in  1  stage holds a valid instruction
halt_in  in  1  instruction requests halt
flush  out  1  flush upstream stages
flush_addr  out  XLEN  refetch address (TRAP_VEC)
halt_out  out  1  core halted (sticky)
wr_addr  out  REG_ADDR_W  regfile write address
wr_data  out  XLEN  regfile write data
wr_enable  out  1  regfile write strobe
trap_epc  out  XLEN  PC of last excepting instruction
trap_cause  out  EX_W  code of last exception
trap_tval  out  32  instr of last excepting instruction
retired  out  CNT_W  retired-instruction count

Behaviour:
- FSM states RUN, TRAP, HALTED. Reset -> RUN.
- Reset values: flush=0, halt_out=0, trap_epc=0, trap_cause=0, trap_tval=0, retired=0, flush counter=0.
- fire = pipeline_valid && state==RUN. Any input presented in TRAP or HALTED is dropped: no write, no count, no capture.
- Commit write (combinational, same cycle):
  - wr_enable = fire && !exception_valid && !nop_instr && opcode in {OP_ARITH, OP_IMM_ARITH, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC} && rd_addr!=0.
  - wr_addr = rd_addr; wr_data = aligned result. Both are driven to 0 whenever wr_enable=0 (no latches).
- Load alignment (OP_LOAD only; other opcodes pass result unchanged):
  - funct 000 = sign-extend byte; 001 = sign-extend half; 010 = word; 100 = zero-extend byte; 101 = zero-extend half.
  - Any other funct passes result unchanged.
- Exception (fire && exception_valid):
  - next edge: state=TRAP, trap_epc<=PC, trap_cause<=exception, trap_tval<=instr.
  - flush=1 and flush_addr=TRAP_VEC for exactly FLUSH_CYCLES cycles starting that edge; then state returns to RUN and flush drops to 0.
  - flush_addr is 0 whenever flush=0.
- Halt (fire && halt_in && !exception_valid):
  - next edge: state=HALTED, halt_out=1.
  - HALTED is left only by reset. The halting instruction still commits its write and counts as retired.
- Simultaneous exception and halt_in: exception wins, no halt.
- retired increments by 1 on each edge where fire && !exception_valid && !nop_instr; wraps modulo 2^CNT_W.
- Reset asserted in TRAP: flush=0 at next edge, counter cleared, state=RUN.
- Trap registers hold their values until the next exception or reset.

Decomposition:
- Opcode constants (OP_*), load funct codes, and XLEN/EX_W defaults live in the shared def_params include.
- FSM state encoding stays local to the module.
- One combinational sub-module, load_align: inputs funct and result; output aligned data.

Test Plan:
1. reset, then OP_ARITH, rd=5, result=32'h1234 -> same cycle wr_enable=1, wr_addr=5, wr_data=32'h1234; retired=1 after the edge.
2. OP_LOAD, funct=000, result=32'h0000_0080 -> wr_data=32'hFFFF_FF80; repeat with funct=100 -> wr_data=32'h0000_0080; OP_ARITH with rd=0 -> wr_enable=0, retired still increments.
3. Exception code 2 at PC=32'h40, instr=32'hFFFF_FFFF, FLUSH_CYCLES=2 -> flush=1 and flush_addr=32'h100 for exactly 2 cycles; trap_epc=32'h40, trap_cause=2, trap_tval=32'hFFFF_FFFF; valid instructions during the flush give wr_enable=0 and no retired change.
4. halt_in with OP_LUI, rd=3 -> write occurs; halt_out=1 next cycle and stays 1 through 10 later valid instructions (no writes); reset -> halt_out=0.
5. Simultaneous exception_valid and halt_in -> flush pulse occurs, halt_out stays 0; reset asserted on the first flush cycle -> flush=0 next cycle and the FSM accepts a write the following cycle.
6. Counter wrap with CNT_W=4: 16 valid retirements -> retired returns to 0; nop_instr bubbles never increment it.
